// File: rtl/palette_selector.sv
// palette_selector: drawing-colour selector for the paint pipeline.
// Picks a palette index from priority-encoded switches (mode=0) or by
// stepping with a push-button (mode=1). While the erase tool is active the
// eraser code (all ones) is forced onto color. Every colour change is
// flagged with a one-cycle color_changed pulse.
// Build option: define COLOR_SEL_DEBOUNCE_EN to include the button
// debouncer. Without it, edges are taken straight from the synchroniser.
module palette_selector #(
  parameter int NUM_COLORS      = 7,
  parameter int COLOR_W         = 3,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_COLORS-1:0] sw,
  input  logic                  tool_sel,
  input  logic                  btn_next,
  input  logic                  mode,
  output logic [COLOR_W-1:0]    color,
  output logic                  color_changed
);

  localparam logic [COLOR_W-1:0] ERASE    = '1;
  localparam logic [COLOR_W-1:0] LAST_IDX = COLOR_W'(NUM_COLORS - 1);

  if (NUM_COLORS < 2 || NUM_COLORS > (2 ** COLOR_W) - 1) begin : g_bad_num_colors
    $error("palette_selector: NUM_COLORS out of range for COLOR_W");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("palette_selector: DEBOUNCE_CYCLES must be at least 1");
  end

  logic               sync_a;
  logic               sync_b;
  logic [1:0]         sync_fill;
  logic               armed;
  logic               level;
  logic               level_d;
  logic               rise;
  logic               accept;
  logic [COLOR_W-1:0] sel_idx;
  logic [COLOR_W-1:0] sel_next;
  logic [COLOR_W-1:0] hi_idx;
  logic [COLOR_W-1:0] color_next;
  logic               changed_d;

  // Two-flop synchroniser; sync_fill marks when sync_b carries a real sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a    <= 1'b0;
      sync_b    <= 1'b0;
      sync_fill <= 2'b00;
    end else begin
      sync_a    <= btn_next;
      sync_b    <= sync_a;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  // A button held through reset must be seen released before presses count.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 1'b0;
    end else if (sync_fill[1] && !sync_b) begin
      armed <= 1'b1;
    end
  end

`ifdef COLOR_SEL_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] db_cnt;

  // Debouncer: accept a level change only after it has held long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      level  <= 1'b0;
      db_cnt <= '0;
    end else if (sync_b == level) begin
      db_cnt <= '0;
    end else if (db_cnt == CNT_LAST) begin
      level  <= sync_b;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + CNT_W'(1);
    end
  end
`else
  assign level = sync_b;
`endif

  // Previous button level for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  assign rise   = level & ~level_d;
  assign accept = rise & armed;

  // Priority encoder: the highest set switch wins.
  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < NUM_COLORS; i++) begin
      if (sw[i]) begin
        hi_idx = COLOR_W'(i);
      end
    end
  end

  // Next selection and colour; the eraser freezes the selection.
  always_comb begin
    sel_next = sel_idx;
    if (!tool_sel) begin
      if (!mode) begin
        if (|sw) begin
          sel_next = hi_idx;
        end
      end else if (accept) begin
        sel_next = (sel_idx == LAST_IDX) ? '0 : sel_idx + COLOR_W'(1);
      end
    end
    color_next = tool_sel ? ERASE : sel_next;
  end

  // Selection/colour registers; change flag is delayed one edge into the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_idx       <= '0;
      color         <= '0;
      changed_d     <= 1'b0;
      color_changed <= 1'b0;
    end else begin
      sel_idx       <= sel_next;
      color         <= color_next;
      changed_d     <= (color_next != color);
      color_changed <= changed_d;
    end
  end

endmodule

// File: tb/tb_palette_selector.sv
// Testbench for palette_selector: scoreboard of expected colour changes
// (value and arrival edge) pushed at stimulus time, popped by a monitor.
module tb_palette_selector;

  localparam int NUM_COLORS      = 7;
  localparam int COLOR_W         = 3;
  localparam int DEBOUNCE_CYCLES = 4;
`ifdef COLOR_SEL_DEBOUNCE_EN
  localparam int BTN_LAT = DEBOUNCE_CYCLES + 3;
`else
  localparam int BTN_LAT = 3;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_COLORS-1:0] sw;
  logic                  tool_sel;
  logic                  btn_next;
  logic                  mode;
  logic [COLOR_W-1:0]    color;
  logic                  color_changed;

  palette_selector #(
    .NUM_COLORS(NUM_COLORS),
    .COLOR_W(COLOR_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw(sw),
    .tool_sel(tool_sel),
    .btn_next(btn_next),
    .mode(mode),
    .color(color),
    .color_changed(color_changed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int color;
    int cyc;
  } sb_t;

  sb_t sb_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  pulse_cnt = 0;
  int  exp_sel = 0;
  bit  mon_en = 1'b0;
  int  prev_color = 0;
  bit  last_chg = 1'b0;
  bit  rst_hist = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic push_exp(input int v, input int at);
    sb_t e;
    e.color = v;
    e.cyc   = at;
    sb_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input bit expect_adv);
    if (expect_adv) begin
      exp_sel = (exp_sel + 1) % NUM_COLORS;
      push_exp(exp_sel, cyc + BTN_LAT);
    end
    btn_next = 1'b1;
    step(6);
    btn_next = 1'b0;
    step(10);
  endtask

  // Monitor: pops a scoreboard entry per colour change, checks the pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      bit chg;
      bit exp_pulse;
      sb_t e;
      exp_pulse = last_chg && !rst_hist;
      check_val("pulse", int'(color_changed), int'(exp_pulse));
      if (color_changed) pulse_cnt++;
      chg = (int'(color) != prev_color);
      if (chg) begin
        if (sb_q.size() == 0) begin
          check_val("unexpected_change", int'(color), prev_color);
        end else begin
          e = sb_q.pop_front();
          check_val("color", int'(color), e.color);
          check_val("latency", cyc, e.cyc);
        end
      end
      last_chg   = chg && !rst_hist;
      prev_color = int'(color);
      rst_hist   = rst;
    end
  end

  initial begin
    int c;
    int g;
    int base;
    rst      = 1'b1;
    sw       = '0;
    tool_sel = 1'b0;
    btn_next = 1'b0;
    mode     = 1'b0;
    step(3);
    check_val("reset_color", int'(color), 0);
    check_val("reset_changed", int'(color_changed), 0);
    mon_en = 1'b1;
    rst    = 1'b0;

    // Idle with no switches: nothing moves.
    step(10);
    check_val("idle_color", int'(color), 0);
    check_val("idle_pulses", pulse_cnt, 0);

    // Switch mode: highest set bit wins, sw=0 holds.
    base = pulse_cnt;
    push_exp(4, cyc + 1);
    sw = 7'b0010110;
    step(1);
    sw = '0;
    step(5);
    check_val("sw_hold_color", int'(color), 4);
    check_val("sw_pulses", pulse_cnt - base, 1);
    push_exp(6, cyc + 1);
    push_exp(5, cyc + 2);
    sw = 7'b1000001;
    step(1);
    sw = 7'b0100000;
    step(1);
    sw = '0;
    step(3);
    sw = 7'b0100000;
    step(1);
    sw = '0;
    step(3);
    check_val("sw_same_pulses", pulse_cnt - base, 3);
    exp_sel = 5;

    // Cycle mode: six presses from 5 wrap through 0; switches ignored.
    mode = 1'b1;
    sw   = 7'h7F;
    step(2);
    for (int i = 0; i < 6; i++) press(1'b1);
    check_val("cycle_color", int'(color), 4);
    sw = '0;

    // Bounce then a long hold.
    g = cyc;
`ifdef COLOR_SEL_DEBOUNCE_EN
    exp_sel = (exp_sel + 1) % NUM_COLORS;
    push_exp(exp_sel, g + 10 + BTN_LAT);
`else
    exp_sel = (exp_sel + 1) % NUM_COLORS;
    push_exp(exp_sel, g + BTN_LAT);
    exp_sel = (exp_sel + 1) % NUM_COLORS;
    push_exp(exp_sel, g + 5 + BTN_LAT);
    exp_sel = (exp_sel + 1) % NUM_COLORS;
    push_exp(exp_sel, g + 10 + BTN_LAT);
`endif
    btn_next = 1'b1; step(3);
    btn_next = 1'b0; step(2);
    btn_next = 1'b1; step(3);
    btn_next = 1'b0; step(2);
    btn_next = 1'b1; step(6);
    btn_next = 1'b0; step(10);
    check_val("bounce_color", int'(color), exp_sel);

    // Eraser: forced code, frozen selection, two pulses.
    mode = 1'b0;
    push_exp(3, cyc + 1);
    sw = 7'b0001000;
    step(1);
    sw = '0;
    exp_sel = 3;
    step(4);
    base = pulse_cnt;
    push_exp(7, cyc + 1);
    tool_sel = 1'b1;
    step(2);
    check_val("erase_color", int'(color), 7);
    mode = 1'b1;
    press(1'b0);
    push_exp(3, cyc + 1);
    tool_sel = 1'b0;
    step(4);
    check_val("erase_release_color", int'(color), 3);
    check_val("erase_pulses", pulse_cnt - base, 2);

    // Reset mid-debounce with the button held through release.
    c = cyc;
    btn_next = 1'b1;
    step(1);
    push_exp(0, cyc + 1);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    exp_sel = 0;
    step(12);
    check_val("held_after_reset", int'(color), 0);
    btn_next = 1'b0;
    step(8);
    press(1'b1);
    check_val("repress_color", int'(color), 1);
    check_val("reset_window", cyc - c > 0 ? 1 : 0, 1);

    step(5);
    check_val("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got cycle %0d expected finish", cyc);
    $fatal(1);
  end

endmodule

// File: doc/palette_selector.md
# palette_selector

Parametrised drawing-colour selector for the paint pipeline; next generation of the 7-switch colour picker. Selects a palette index either from priority-encoded switches or by stepping through the palette with a debounced push-button, overrides with the eraser code while the erase tool is active, and flags every colour change with a one-cycle pulse for the canvas writer.

## Interface

- NUM_COLORS, 7: palette entries, indices 0..NUM_COLORS-1; legal range 2..2^COLOR_W-1.
- COLOR_W, 3: colour code width.
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles required to accept a button level change; minimum 1.

- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- sw  in  NUM_COLORS  colour switches; bit i requests index i.
- tool_sel  in  1  1 = erase tool active.
- btn_next  in  1  raw, asynchronous, bouncy push-button.
- mode  in  1  0 = switch mode, 1 = cycle mode.
- color  out  COLOR_W  registered colour code.
- color_changed  out  1  one-cycle pulse after color changes.

## Operation

- ERASE = 2^COLOR_W-1 (all ones); never a palette index.
- Internal sel_idx (COLOR_W bits) holds the current palette selection.
- Switch mode (mode=0): if any sw bit is set, sel_idx <= index of the highest set bit. If sw = 0, sel_idx holds. btn_next pulses are ignored.
- Cycle mode (mode=1): sw ignored; each accepted btn_next rising edge advances sel_idx: sel_idx+1, wrapping NUM_COLORS-1 -> 0.
- Eraser: while tool_sel=1, color = ERASE. sel_idx is frozen: no sw or button updates, and accepted presses are dropped. On tool_sel release, color returns to sel_idx.
- Button path:
  - Two-flop synchroniser, then debouncer.
  - The debouncer counter increments each cycle the synchronised level differs from the stable level, and clears when they match.
  - When the counter is at DEBOUNCE_CYCLES-1 and the levels still differ, the stable level flips and the counter clears.
  - A rising edge of the stable level produces one accept pulse.
- Switching mode never alters sel_idx by itself. In switch mode, sel_idx is overwritten on the next cycle only if some sw bit is set.
- color is computed from the next-state sel_idx and tool_sel, so sel_idx and color update on the same edge.
- color_changed = 1 for exactly the cycle following any edge where color took a new value; a value rewritten with itself gives no pulse.

## Timing

- Reset values: color=0, color_changed=0, sel_idx=0, synchronisers=0, stable level=0, counter=0.
- Reset has priority over all inputs. Reset mid-debounce discards the press in progress; a button held through reset release must be released and pressed again.
- Switch latency: sw sampled at edge N gives color valid after edge N, and color_changed high during cycle N+1 to N+2.
- tool_sel latency: same as switch latency, 1 edge.
- Button latency (debounce on): a clean press first sampled high at edge 0 updates color at edge DEBOUNCE_CYCLES+2.
- Bounce shorter than DEBOUNCE_CYCLES cycles produces no pulse. Each accepted press advances exactly one step, however long it is held.

## Configuration

- COLOR_SEL_DEBOUNCE_EN defined: debouncer present, as described above.
- Undefined: counter and stable register removed; edge detection runs directly on the synchroniser output. A clean press sampled at edge 0 updates color at edge 2. DEBOUNCE_CYCLES is ignored. This build is for simulation and externally debounced buttons.

## Test plan

All scenarios use NUM_COLORS=7, COLOR_W=3, DEBOUNCE_CYCLES=4, debounce enabled.

- Reset, then sw=0 for 10 cycles -> color=0, color_changed stays 0.
- mode=0, sw=7'b0010110 -> color=4 one edge later, one color_changed pulse. Then sw=0 -> color holds 4, no pulse.
- mode=1, six clean presses from index 5 -> color sequence 6,0,1,2,3,4; each update lands exactly 6 edges after press start.
- mode=1, btn_next glitches high for 3 cycles, low 2, high 3 -> no change. Then held 6 cycles -> exactly one advance.
- tool_sel=1 with color=3 -> color=7 after 1 edge. Press during erase -> no effect. Release -> color=3, two total pulses.
- Assert rst mid-debounce with btn held -> color=0. After reset release, no advance until the button is released and pressed again.
